// File: rtl/wb_select_stage_if.sv
// Bus bundle for wb_select_stage: upstream instruction, memory response,
// flush, and the registered writeback beat.
interface wb_select_stage_if #(
   parameter int WIDTH   = 32,
   parameter int REGADDR = 5
);
   localparam int OFFW = $clog2(WIDTH / 8);

   logic               in_valid;
   logic               in_ready;
   logic [1:0]         wb_sel;
   logic [1:0]         ld_size;
   logic               ld_unsigned;
   logic [OFFW-1:0]    byte_off;
   logic [WIDTH-1:0]   alu_result;
   logic [WIDTH-1:0]   pc_plus4;
   logic [WIDTH-1:0]   imm;
   logic [REGADDR-1:0] rd_addr;
   logic               reg_write;
   logic               mem_rvalid;
   logic [WIDTH-1:0]   mem_rdata;
   logic               flush;
   logic               out_valid;
   logic [WIDTH-1:0]   wb_data;
   logic [REGADDR-1:0] wb_addr;
   logic               wb_we;

   modport master (
      output in_valid, wb_sel, ld_size, ld_unsigned, byte_off,
             alu_result, pc_plus4, imm, rd_addr, reg_write,
             mem_rvalid, mem_rdata, flush,
      input  in_ready, out_valid, wb_data, wb_addr, wb_we
   );

   modport slave (
      input  in_valid, wb_sel, ld_size, ld_unsigned, byte_off,
             alu_result, pc_plus4, imm, rd_addr, reg_write,
             mem_rvalid, mem_rdata, flush,
      output in_ready, out_valid, wb_data, wb_addr, wb_we
   );
endinterface

// File: rtl/wb_select_stage.sv
// Registered writeback stage: four-way source select, load wait with
// sub-word extraction/extension, and flush with in-flight load drain.
module wb_select_stage #(
   parameter int WIDTH   = 32,
   parameter int REGADDR = 5
) (
   input  logic              clk,
   input  logic              reset,
   wb_select_stage_if.slave  bus
);
   localparam int OFFW = $clog2(WIDTH / 8);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_MEM,
      S_DRAIN
   } state_t;

   state_t             state;
   logic [1:0]         size_q;
   logic               uns_q;
   logic [OFFW-1:0]    off_q;
   logic [REGADDR-1:0] rd_q;
   logic               rw_q;

   logic               out_valid_q;
   logic [WIDTH-1:0]   wb_data_q;
   logic [REGADDR-1:0] wb_addr_q;
   logic               wb_we_q;

   logic [WIDTH-1:0]   src_sel;
   logic [OFFW-1:0]    lane;
   logic [WIDTH-1:0]   shifted;
   logic [WIDTH-1:0]   mask;
   logic               sign;
   logic [WIDTH-1:0]   ld_value;
   logic               accept;

   assign accept = (state == S_IDLE) && bus.in_valid && !bus.flush;

   always_comb begin
      src_sel = bus.alu_result;
      case (bus.wb_sel)
         2'b10:   src_sel = bus.pc_plus4;
         2'b11:   src_sel = bus.imm;
         default: src_sel = bus.alu_result;
      endcase
   end

   // Align the addressed lane to bit 0, then keep the access width and
   // fill the upper bits with either zeros or the access-width sign bit.
   always_comb begin
      lane = off_q;
      case (size_q)
         2'b01:   lane[0]   = 1'b0;
         2'b10:   lane[1:0] = 2'b00;
         2'b11:   lane      = '0;
         default: lane      = off_q;
      endcase
      shifted = bus.mem_rdata >> {lane, 3'b000};
      case (size_q)
         2'b00: begin
            mask = WIDTH'(8'hFF);
            sign = shifted[7];
         end
         2'b01: begin
            mask = WIDTH'(16'hFFFF);
            sign = shifted[15];
         end
         2'b10: begin
            mask = WIDTH'(32'hFFFF_FFFF);
            sign = shifted[31];
         end
         default: begin
            mask = '1;
            sign = shifted[WIDTH-1];
         end
      endcase
      ld_value = (shifted & mask) | ((sign && !uns_q) ? ~mask : '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         size_q      <= '0;
         uns_q       <= 1'b0;
         off_q       <= '0;
         rd_q        <= '0;
         rw_q        <= 1'b0;
         out_valid_q <= 1'b0;
         wb_data_q   <= '0;
         wb_addr_q   <= '0;
         wb_we_q     <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         wb_we_q     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  size_q <= bus.ld_size;
                  uns_q  <= bus.ld_unsigned;
                  off_q  <= bus.byte_off;
                  rd_q   <= bus.rd_addr;
                  rw_q   <= bus.reg_write;
                  if (bus.wb_sel == 2'b01) begin
                     state <= S_WAIT_MEM;
                  end else begin
                     out_valid_q <= 1'b1;
                     wb_data_q   <= src_sel;
                     wb_addr_q   <= bus.rd_addr;
                     wb_we_q     <= bus.reg_write && (bus.rd_addr != '0);
                  end
               end
            end
            S_WAIT_MEM: begin
               // Flush coinciding with the data still retires the load silently.
               if (bus.mem_rvalid) begin
                  state <= S_IDLE;
                  if (!bus.flush) begin
                     out_valid_q <= 1'b1;
                     wb_data_q   <= ld_value;
                     wb_addr_q   <= rd_q;
                     wb_we_q     <= rw_q && (rd_q != '0);
                  end
               end else if (bus.flush) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (bus.mem_rvalid) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.wb_data   = wb_data_q;
   assign bus.wb_addr   = wb_addr_q;
   assign bus.wb_we     = wb_we_q;
endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: vector table, directed flush/reset
// sequences and random instructions against an arithmetic reference model.
module tb_wb_select_stage;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   wb_select_stage_if #(.WIDTH(32), .REGADDR(5)) b32 ();
   wb_select_stage_if #(.WIDTH(64), .REGADDR(5)) b64 ();

   wb_select_stage #(.WIDTH(32), .REGADDR(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b32.slave)
   );

   wb_select_stage #(.WIDTH(64), .REGADDR(5)) dut64 (
      .clk   (clk),
      .reset (reset),
      .bus   (b64.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  sel;
      logic [1:0]  size;
      logic        uns;
      logic [1:0]  off;
      logic [31:0] src;
      logic [4:0]  rd;
      logic        rw;
      logic [31:0] rdata;
      int          d;
      logic [31:0] exp_data;
      logic        exp_we;
   } vec_t;

   vec_t tbl[11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Load result as a number: take nb bytes from the aligned lane, then
   // subtract 2^(8*nb) when signed and negative (wraps to WIDTH bits).
   function automatic logic [63:0] model_load(input logic [63:0] rdata, input int w,
                                              input logic [1:0] size, input logic uns,
                                              input int off);
      int nb;
      int lane;
      logic [127:0] v;
      logic [127:0] span;
      nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : w / 8;
      lane = (off / nb) * nb;
      span = 128'd1 << (8 * nb);
      v    = ({64'd0, rdata} >> (8 * lane)) % span;
      if (!uns && (v >= (span >> 1))) v = v - span;
      return (w == 32) ? {32'd0, v[31:0]} : v[63:0];
   endfunction

   task automatic scramble32();
      b32.wb_sel      = 2'($urandom);
      b32.ld_size     = 2'($urandom);
      b32.ld_unsigned = 1'($urandom);
      b32.byte_off    = 2'($urandom);
      b32.rd_addr     = 5'($urandom);
      b32.reg_write   = 1'($urandom);
   endtask

   task automatic issue(input string tag, input logic [1:0] sel, input logic [1:0] size,
                        input logic uns, input logic [1:0] off, input logic [31:0] src,
                        input logic [4:0] rd, input logic rw, input logic [31:0] rdata,
                        input int d, input logic [31:0] exp_data, input logic exp_we);
      chk({tag, ".ready_idle"}, b32.in_ready, 1);
      b32.in_valid    = 1'b1;
      b32.wb_sel      = sel;
      b32.ld_size     = size;
      b32.ld_unsigned = uns;
      b32.byte_off    = off;
      b32.alu_result  = (sel == 2'b00) ? src : ~src;
      b32.pc_plus4    = (sel == 2'b10) ? src : src ^ 32'h5A5A_0000;
      b32.imm         = (sel == 2'b11) ? src : src + 32'd3;
      b32.rd_addr     = rd;
      b32.reg_write   = rw;
      tick();
      b32.in_valid = 1'b0;
      scramble32();
      if (sel == 2'b01) begin
         for (int k = 1; k < d; k++) begin
            chk({tag, ".ready_wait"}, b32.in_ready, 0);
            chk({tag, ".valid_wait"}, b32.out_valid, 0);
            tick();
         end
         chk({tag, ".ready_wait"}, b32.in_ready, 0);
         b32.mem_rvalid = 1'b1;
         b32.mem_rdata  = rdata;
         tick();
         b32.mem_rvalid = 1'b0;
         b32.mem_rdata  = $urandom;
      end
      chk({tag, ".out_valid"}, b32.out_valid, 1);
      chk({tag, ".wb_data"}, b32.wb_data, exp_data);
      chk({tag, ".wb_addr"}, b32.wb_addr, rd);
      chk({tag, ".wb_we"}, b32.wb_we, exp_we);
      tick();
      chk({tag, ".valid_drop"}, b32.out_valid, 0);
      chk({tag, ".we_drop"}, b32.wb_we, 0);
      chk({tag, ".data_hold"}, b32.wb_data, exp_data);
   endtask

   task automatic issue64(input string tag, input logic [1:0] size, input logic uns,
                          input logic [2:0] off, input logic [63:0] rdata,
                          input logic [63:0] exp_data);
      chk({tag, ".ready"}, b64.in_ready, 1);
      b64.in_valid    = 1'b1;
      b64.wb_sel      = 2'b01;
      b64.ld_size     = size;
      b64.ld_unsigned = uns;
      b64.byte_off    = off;
      b64.rd_addr     = 5'd9;
      b64.reg_write   = 1'b1;
      tick();
      b64.in_valid   = 1'b0;
      b64.byte_off   = 3'($urandom);
      b64.ld_size    = 2'($urandom);
      b64.mem_rvalid = 1'b1;
      b64.mem_rdata  = rdata;
      tick();
      b64.mem_rvalid = 1'b0;
      chk({tag, ".out_valid"}, b64.out_valid, 1);
      chk({tag, ".wb_data"}, b64.wb_data, exp_data);
      tick();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      {b32.in_valid, b32.wb_sel, b32.ld_size, b32.ld_unsigned, b32.byte_off} = '0;
      {b32.alu_result, b32.pc_plus4, b32.imm, b32.rd_addr, b32.reg_write} = '0;
      {b32.mem_rvalid, b32.mem_rdata, b32.flush} = '0;
      {b64.in_valid, b64.wb_sel, b64.ld_size, b64.ld_unsigned, b64.byte_off} = '0;
      {b64.alu_result, b64.pc_plus4, b64.imm, b64.rd_addr, b64.reg_write} = '0;
      {b64.mem_rvalid, b64.mem_rdata, b64.flush} = '0;

      tbl[0]  = '{2'b00, 2'b00, 1'b0, 2'd0, 32'h0000_1234, 5'd5,  1'b1, 32'h0,         1, 32'h0000_1234, 1'b1};
      tbl[1]  = '{2'b01, 2'b00, 1'b0, 2'd2, 32'h0,         5'd6,  1'b1, 32'h0080_0000, 3, 32'hFFFF_FF80, 1'b1};
      tbl[2]  = '{2'b01, 2'b00, 1'b1, 2'd2, 32'h0,         5'd6,  1'b1, 32'h0080_0000, 3, 32'h0000_0080, 1'b1};
      tbl[3]  = '{2'b01, 2'b01, 1'b0, 2'd3, 32'h0,         5'd7,  1'b1, 32'h9ABC_0000, 1, 32'hFFFF_9ABC, 1'b1};
      tbl[4]  = '{2'b11, 2'b00, 1'b0, 2'd0, 32'h0000_0007, 5'd0,  1'b1, 32'h0,         1, 32'h0000_0007, 1'b0};
      tbl[5]  = '{2'b10, 2'b00, 1'b0, 2'd0, 32'h0000_0040, 5'd31, 1'b0, 32'h0,         1, 32'h0000_0040, 1'b0};
      tbl[6]  = '{2'b01, 2'b10, 1'b0, 2'd3, 32'h0,         5'd8,  1'b1, 32'h8765_4321, 2, 32'h8765_4321, 1'b1};
      tbl[7]  = '{2'b01, 2'b11, 1'b0, 2'd1, 32'h0,         5'd9,  1'b1, 32'hF000_0001, 1, 32'hF000_0001, 1'b1};
      tbl[8]  = '{2'b01, 2'b01, 1'b1, 2'd1, 32'h0,         5'd10, 1'b1, 32'h1234_FFFF, 4, 32'h0000_FFFF, 1'b1};
      tbl[9]  = '{2'b01, 2'b00, 1'b0, 2'd3, 32'h0,         5'd11, 1'b1, 32'h7F00_00FF, 1, 32'h0000_007F, 1'b1};
      tbl[10] = '{2'b00, 2'b00, 1'b0, 2'd0, 32'hCAFE_F00D, 5'd3,  1'b0, 32'h0,         1, 32'hCAFE_F00D, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst.in_ready", b32.in_ready, 1);
      chk("rst.out_valid", b32.out_valid, 0);
      chk("rst.wb_we", b32.wb_we, 0);
      chk("rst.wb_data", b32.wb_data, 0);
      chk("rst.wb_addr", b32.wb_addr, 0);
      reset = 1'b0;
      tick();

      foreach (tbl[i])
         issue($sformatf("vec%0d", i), tbl[i].sel, tbl[i].size, tbl[i].uns, tbl[i].off,
               tbl[i].src, tbl[i].rd, tbl[i].rw, tbl[i].rdata, tbl[i].d,
               tbl[i].exp_data, tbl[i].exp_we);

      // Flush in WAIT_MEM, repeated flush in DRAIN, data two cycles later.
      b32.in_valid = 1'b1; b32.wb_sel = 2'b01; b32.ld_size = 2'b00; b32.rd_addr = 5'd4;
      b32.reg_write = 1'b1;
      tick();
      b32.in_valid = 1'b0;
      b32.flush = 1'b1;
      tick();
      chk("drain.ready0", b32.in_ready, 0);
      tick();
      b32.flush = 1'b0;
      chk("drain.ready1", b32.in_ready, 0);
      chk("drain.valid1", b32.out_valid, 0);
      b32.mem_rvalid = 1'b1;
      b32.mem_rdata  = 32'h1111_1111;
      tick();
      b32.mem_rvalid = 1'b0;
      chk("drain.no_wb", b32.out_valid, 0);
      chk("drain.ready_back", b32.in_ready, 1);
      issue("drain.pc4", 2'b10, 2'b00, 1'b0, 2'd0, 32'h0000_0040, 5'd12, 1'b1, 32'h0, 1,
            32'h0000_0040, 1'b1);

      // Flush and mem_rvalid in the same WAIT_MEM cycle.
      b32.in_valid = 1'b1; b32.wb_sel = 2'b01;
      tick();
      b32.in_valid = 1'b0;
      b32.flush = 1'b1; b32.mem_rvalid = 1'b1;
      tick();
      b32.flush = 1'b0; b32.mem_rvalid = 1'b0;
      chk("flushrv.no_wb", b32.out_valid, 0);
      chk("flushrv.ready", b32.in_ready, 1);

      // Flush in IDLE blocks acceptance; stray mem_rvalid in IDLE ignored.
      b32.in_valid = 1'b1; b32.wb_sel = 2'b00; b32.flush = 1'b1;
      tick();
      b32.in_valid = 1'b0; b32.flush = 1'b0;
      chk("idleflush.no_wb", b32.out_valid, 0);
      chk("idleflush.ready", b32.in_ready, 1);
      b32.mem_rvalid = 1'b1;
      tick();
      b32.mem_rvalid = 1'b0;
      chk("idlerv.no_wb", b32.out_valid, 0);
      chk("idlerv.ready", b32.in_ready, 1);

      // Four back-to-back non-MEM accepts.
      b32.in_valid = 1'b1; b32.reg_write = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b32.wb_sel     = (i == 1) ? 2'b10 : (i == 2) ? 2'b11 : 2'b00;
         b32.alu_result = 32'h100 + 32'(i);
         b32.pc_plus4   = 32'h200 + 32'(i);
         b32.imm        = 32'h300 + 32'(i);
         b32.rd_addr    = 5'(i + 1);
         tick();
         chk($sformatf("b2b%0d.valid", i), b32.out_valid, 1);
         chk($sformatf("b2b%0d.data", i), b32.wb_data,
             (i == 1) ? 32'h201 : (i == 2) ? 32'h302 : 32'h100 + 32'(i));
         chk($sformatf("b2b%0d.addr", i), b32.wb_addr, 5'(i + 1));
         chk($sformatf("b2b%0d.ready", i), b32.in_ready, 1);
      end
      b32.in_valid = 1'b0;
      tick();
      chk("b2b.end", b32.out_valid, 0);

      // Asynchronous reset while waiting on a load.
      b32.in_valid = 1'b1; b32.wb_sel = 2'b01; b32.rd_addr = 5'd13;
      tick();
      b32.in_valid = 1'b0;
      tick();
      #3 reset = 1'b1;
      #1;
      chk("arst.ready", b32.in_ready, 1);
      chk("arst.data", b32.wb_data, 0);
      chk("arst.addr", b32.wb_addr, 0);
      #1 reset = 1'b0;
      tick();
      b32.mem_rvalid = 1'b1;
      tick();
      b32.mem_rvalid = 1'b0;
      chk("arst.stray", b32.out_valid, 0);
      chk("arst.ready2", b32.in_ready, 1);

      for (int n = 0; n < 200; n++) begin
         logic [1:0]  sel, size;
         logic [1:0]  off;
         logic        uns, rw;
         logic [31:0] src, rdata, exp;
         logic [4:0]  rd;
         sel   = 2'($urandom);
         size  = 2'($urandom);
         off   = 2'($urandom);
         uns   = 1'($urandom);
         rw    = 1'($urandom);
         rd    = 5'($urandom);
         src   = $urandom;
         rdata = $urandom;
         exp   = (sel == 2'b01) ? model_load({32'd0, rdata}, 32, size, uns, int'(off))
                                : src;
         issue($sformatf("rnd%0d", n), sel, size, uns, off, src, rd, rw, rdata,
               int'($urandom_range(1, 4)), exp, rw && (rd != 5'd0));
      end

      issue64("w64.lw", 2'b10, 1'b0, 3'd4, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001);
      for (int n = 0; n < 60; n++) begin
         logic [1:0]  size;
         logic [2:0]  off;
         logic        uns;
         logic [63:0] rdata;
         size  = 2'($urandom);
         off   = 3'($urandom);
         uns   = 1'($urandom);
         rdata = {$urandom, $urandom};
         issue64($sformatf("w64rnd%0d", n), size, uns, off, rdata,
                 model_load(rdata, 64, size, uns, int'(off)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
